// File: rtl/tile_blitter.sv
// Copies one 32x32 12-bit tile from a tile ROM into frame VRAM port A at a tile-grid slot.
// Define TILE_BLIT_KEY_EN to skip pixels equal to KEY_COLOR (transparent colour keying).
module tile_blitter #(
  parameter int          H_RES     = 640,
  parameter int          H_TILES   = 20,
  parameter int          V_TILES   = 15,
  parameter logic [11:0] KEY_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_sel,
  input  logic [4:0]  cmd_tx,
  input  logic [3:0]  cmd_ty,
  output logic [9:0]  rom_addr,
  input  logic [11:0] bg_data,
  input  logic [11:0] chr_data,
  input  logic [11:0] wall_data,
  output logic        vram_we,
  output logic [18:0] vram_addr,
  output logic [11:0] vram_data,
  output logic        busy,
  output logic        done,
  output logic        cmd_err
);

`ifdef TILE_BLIT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  localparam logic [5:0]  H_TILES_W = 6'(H_TILES);
  localparam logic [4:0]  V_TILES_W = 5'(V_TILES);
  localparam logic [18:0] H_RES_W   = 19'(H_RES);
  localparam logic [9:0]  LAST_PIX  = 10'd1023;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  state_t      state, state_next;
  logic [1:0]  sel_q;
  logic [4:0]  tx_q;
  logic [3:0]  ty_q;
  logic [9:0]  p;
  logic        err_q;
  logic        accept;
  logic        cmd_illegal;
  logic [11:0] pix_word;
  logic        pix_write;
  logic [8:0]  pix_y;
  logic [9:0]  pix_x;
  logic [18:0] line_base;
  logic [18:0] pix_addr;

  assign accept      = (state == IDLE) && cmd_valid;
  assign cmd_illegal = (cmd_sel == 2'd3) || ({1'b0, cmd_tx} >= H_TILES_W) ||
                       ({1'b0, cmd_ty} >= V_TILES_W);
  assign rom_addr    = p;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    cmd_err    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (accept) state_next = cmd_illegal ? FIN : RUN;
      end
      RUN:   if (p == LAST_PIX) state_next = FLUSH;
      FLUSH: state_next = FIN;
      FIN: begin
        done       = 1'b1;
        cmd_err    = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (sel_q)
      2'd0:    pix_word = bg_data;
      2'd1:    pix_word = chr_data;
      2'd2:    pix_word = wall_data;
      default: pix_word = 12'h000;
    endcase
  end

  // Keying folds to a constant 1 when the feature is compiled out.
  assign pix_write = !KEY_EN || (pix_word != KEY_COLOR);

  // Line pitch multiply built from the set bits of H_RES; for 640 this is (y<<9)+(y<<7).
  assign pix_y = {ty_q, p[9:5]};
  assign pix_x = {tx_q, p[4:0]};

  always_comb begin
    line_base = '0;
    for (int i = 0; i < 19; i++) begin
      if (H_RES_W[i]) line_base = line_base + (19'(pix_y) << i);
    end
    pix_addr = line_base + 19'(pix_x);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      p         <= '0;
      err_q     <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      if (accept) begin
        sel_q <= cmd_sel;
        tx_q  <= cmd_tx;
        ty_q  <= cmd_ty;
        p     <= '0;
        err_q <= cmd_illegal;
      end
      if (state == RUN && p != LAST_PIX) p <= p + 10'd1;
      vram_we <= (state == RUN) && pix_write;
      if (state == RUN && pix_write) begin
        vram_addr <= pix_addr;
        vram_data <= pix_word;
      end
    end
  end

endmodule

// File: tb/tb_tile_blitter.sv
// Self-checking bench for tile_blitter: random ROM contents and commands against an arithmetic model.
// Honors TILE_BLIT_KEY_EN so the same bench covers both builds.
module tb_tile_blitter;
  localparam int          MAXC      = 2100;
  localparam logic [11:0] KEY_COLOR = 12'h000;
`ifdef TILE_BLIT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready;
  logic [1:0]  cmd_sel;
  logic [4:0]  cmd_tx;
  logic [3:0]  cmd_ty;
  logic [9:0]  rom_addr;
  logic [11:0] bg_data, chr_data, wall_data;
  logic        vram_we;
  logic [18:0] vram_addr;
  logic [11:0] vram_data;
  logic        busy, done, cmd_err;

  logic [11:0] rom_bg   [1024];
  logic [11:0] rom_chr  [1024];
  logic [11:0] rom_wall [1024];

  logic        obs_we    [MAXC+1];
  logic [18:0] obs_addr  [MAXC+1];
  logic [11:0] obs_data  [MAXC+1];
  logic        obs_done  [MAXC+1];
  logic        obs_err   [MAXC+1];
  logic        obs_ready [MAXC+1];
  logic        obs_busy  [MAXC+1];

  int checks = 0;
  int errors = 0;

  assign bg_data   = rom_bg[rom_addr];
  assign chr_data  = rom_chr[rom_addr];
  assign wall_data = rom_wall[rom_addr];

  tile_blitter dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_tx(cmd_tx), .cmd_ty(cmd_ty), .rom_addr(rom_addr),
    .bg_data(bg_data), .chr_data(chr_data), .wall_data(wall_data),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Reference: pixel p of tile (tx,ty) lands at screen (tx*32+col, ty*32+row) on a 640-wide frame.
  function automatic int exp_addr(input int tx, input int ty, input int p);
    return (ty * 32 + p / 32) * 640 + tx * 32 + p % 32;
  endfunction

  function automatic logic [11:0] rom_word(input int sel, input int p);
    if (sel == 0) return rom_bg[p];
    if (sel == 1) return rom_chr[p];
    return rom_wall[p];
  endfunction

  function automatic bit writes(input logic [11:0] w);
    return !KEY_EN || (w != KEY_COLOR);
  endfunction

  task automatic issue(input logic [1:0] sel, input logic [4:0] tx, input logic [3:0] ty);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_tx    = tx;
    cmd_ty    = ty;
    @(posedge clk);
  endtask

  // Records cycles 1..n after the accept edge; optionally drops valid or swaps fields mid-run.
  task automatic capture(input int n, input int drop_cyc, input int chg_cyc,
                         input logic [4:0] alt_tx, input logic [3:0] alt_ty);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      obs_we[c]    = vram_we;
      obs_addr[c]  = vram_addr;
      obs_data[c]  = vram_data;
      obs_done[c]  = done;
      obs_err[c]   = cmd_err;
      obs_ready[c] = cmd_ready;
      obs_busy[c]  = busy;
      if (c == drop_cyc) cmd_valid = 1'b0;
      if (c == chg_cyc) begin
        cmd_tx = alt_tx;
        cmd_ty = alt_ty;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", cmd_err); end
    checks++; if (vram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", vram_we); end
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (vram_addr !== 19'd0) begin errors++; $display("[TB] FAIL reset_vram_addr: got %0d expected 0", vram_addr); end
    rst = 1'b0;
  endtask

  task automatic test_copy(input int sel, input int tx, input int ty, input bit ramp);
    int  p;
    bit  exp_we;
    for (int i = 0; i < 1024; i++) begin
      rom_bg[i]   = ramp ? 12'(i) : 12'($urandom);
      rom_chr[i]  = 12'($urandom);
      rom_wall[i] = 12'($urandom);
    end
    issue(2'(sel), 5'(tx), 4'(ty));
    capture(1030, 1, 0, 5'd0, 4'd0);
    for (int c = 1; c <= 1030; c++) begin
      p = c - 2;
      exp_we = 1'b0;
      if (c >= 2 && c <= 1025) exp_we = writes(rom_word(sel, p));
      checks++;
      if (obs_we[c] !== exp_we) begin
        errors++; $display("[TB] FAIL copy_we c%0d: got %b expected %b", c, obs_we[c], exp_we);
      end else if (exp_we) begin
        checks++;
        if (obs_addr[c] !== 19'(exp_addr(tx, ty, p))) begin
          errors++; $display("[TB] FAIL copy_addr p%0d: got %0d expected %0d", p, obs_addr[c], exp_addr(tx, ty, p));
        end
        checks++;
        if (obs_data[c] !== rom_word(sel, p)) begin
          errors++; $display("[TB] FAIL copy_data p%0d: got %h expected %h", p, obs_data[c], rom_word(sel, p));
        end
      end
      checks++; if (obs_done[c] !== (c == 1026)) begin errors++; $display("[TB] FAIL copy_done c%0d: got %b expected %b", c, obs_done[c], c == 1026); end
      checks++; if (obs_err[c] !== 1'b0) begin errors++; $display("[TB] FAIL copy_err c%0d: got %b expected 0", c, obs_err[c]); end
      checks++; if (obs_ready[c] !== (c >= 1027)) begin errors++; $display("[TB] FAIL copy_ready c%0d: got %b expected %b", c, obs_ready[c], c >= 1027); end
      checks++; if (obs_busy[c] !== (c <= 1026)) begin errors++; $display("[TB] FAIL copy_busy c%0d: got %b expected %b", c, obs_busy[c], c <= 1026); end
    end
  endtask

  task automatic test_corner();
    int nwe = 0;
    int first_c = 0;
    int last_c = 0;
    bit any_err = 1'b0;
    for (int i = 0; i < 1024; i++) rom_wall[i] = 12'($urandom_range(4095, 1));
    issue(2'd2, 5'd19, 4'd14);
    capture(1030, 1, 0, 5'd0, 4'd0);
    for (int c = 1; c <= 1030; c++) begin
      if (obs_we[c] === 1'b1) begin
        nwe++;
        if (first_c == 0) first_c = c;
        last_c = c;
      end
      if (obs_err[c] === 1'b1) any_err = 1'b1;
    end
    checks++; if (nwe != 1024) begin errors++; $display("[TB] FAIL corner_count: got %0d expected 1024", nwe); end
    checks++; if (first_c == 0 || obs_addr[first_c] !== 19'(exp_addr(19, 14, 0))) begin
      errors++; $display("[TB] FAIL corner_first_addr: got %0d expected %0d", obs_addr[first_c], exp_addr(19, 14, 0));
    end
    checks++; if (last_c == 0 || obs_addr[last_c] !== 19'd307199) begin
      errors++; $display("[TB] FAIL corner_last_addr: got %0d expected 307199", obs_addr[last_c]);
    end
    checks++; if (any_err !== 1'b0) begin errors++; $display("[TB] FAIL corner_err: got %b expected 0", any_err); end
    checks++; if (obs_done[1026] !== 1'b1) begin errors++; $display("[TB] FAIL corner_done: got %b expected 1", obs_done[1026]); end
  endtask

  task automatic test_illegal();
    int sels [4] = '{3, 0, 1, 0};
    int txs  [4] = '{0, 20, 0, 0};
    int tys  [4] = '{0, 0, 15, 0};
    int nwe;
    int ndone;
    sels[3] = $urandom_range(2);
    txs[3]  = $urandom_range(31, 20);
    tys[3]  = $urandom_range(14);
    for (int k = 0; k < 4; k++) begin
      issue(2'(sels[k]), 5'(txs[k]), 4'(tys[k]));
      capture(5, 1, 0, 5'd0, 4'd0);
      nwe = 0;
      ndone = 0;
      for (int c = 1; c <= 5; c++) begin
        if (obs_we[c] !== 1'b0) nwe++;
        if (c >= 2 && obs_done[c] !== 1'b0) ndone++;
      end
      checks++; if (obs_done[1] !== 1'b1) begin errors++; $display("[TB] FAIL illegal_done k%0d: got %b expected 1", k, obs_done[1]); end
      checks++; if (obs_err[1] !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err k%0d: got %b expected 1", k, obs_err[1]); end
      checks++; if (obs_ready[1] !== 1'b0) begin errors++; $display("[TB] FAIL illegal_ready1 k%0d: got %b expected 0", k, obs_ready[1]); end
      checks++; if (obs_ready[2] !== 1'b1) begin errors++; $display("[TB] FAIL illegal_ready2 k%0d: got %b expected 1", k, obs_ready[2]); end
      checks++; if (nwe != 0) begin errors++; $display("[TB] FAIL illegal_writes k%0d: got %0d expected 0", k, nwe); end
      checks++; if (ndone != 0) begin errors++; $display("[TB] FAIL illegal_extra_done k%0d: got %0d expected 0", k, ndone); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] alt_tx;
    logic [3:0] alt_ty;
    int nwe1 = 0;
    int nwe_all = 0;
    int bad_addr = 0;
    int ready_busy = 0;
    int ndone1 = 0;
    int ndone_all = 0;
    alt_tx = 5'($urandom_range(19));
    alt_ty = 4'($urandom_range(14));
    for (int i = 0; i < 1024; i++) rom_bg[i] = 12'($urandom_range(4095, 1));
    issue(2'd0, 5'd3, 4'd5);
    capture(2060, 1028, 10, alt_tx, alt_ty);
    for (int c = 1; c <= 2060; c++) begin
      if (obs_we[c] === 1'b1) nwe_all++;
      if (obs_done[c] === 1'b1) ndone_all++;
      if (c <= 1027) begin
        if (obs_we[c] === 1'b1) begin
          nwe1++;
          if (obs_addr[c] !== 19'(exp_addr(3, 5, c - 2))) bad_addr++;
        end
        if (obs_done[c] === 1'b1) ndone1++;
        if (c <= 1026 && obs_ready[c] !== 1'b0) ready_busy++;
      end
    end
    checks++; if (nwe1 != 1024) begin errors++; $display("[TB] FAIL b2b_first_count: got %0d expected 1024", nwe1); end
    checks++; if (bad_addr != 0) begin errors++; $display("[TB] FAIL b2b_first_addr: got %0d bad expected 0", bad_addr); end
    checks++; if (ready_busy != 0) begin errors++; $display("[TB] FAIL b2b_ready_while_busy: got %0d expected 0", ready_busy); end
    checks++; if (ndone1 != 1 || obs_done[1026] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d expected 1", ndone1); end
    checks++; if (obs_ready[1027] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_1027: got %b expected 1", obs_ready[1027]); end
    checks++; if (obs_busy[1028] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_accept: got %b expected 1", obs_busy[1028]); end
    checks++; if (obs_we[1029] !== 1'b1 || obs_addr[1029] !== 19'(exp_addr(alt_tx, alt_ty, 0))) begin
      errors++; $display("[TB] FAIL b2b_second_first_addr: got %0d expected %0d", obs_addr[1029], exp_addr(alt_tx, alt_ty, 0));
    end
    checks++; if (obs_done[2053] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_done: got %b expected 1", obs_done[2053]); end
    checks++; if (ndone_all != 2) begin errors++; $display("[TB] FAIL b2b_done_total: got %0d expected 2", ndone_all); end
    checks++; if (nwe_all != 2048) begin errors++; $display("[TB] FAIL b2b_write_total: got %0d expected 2048", nwe_all); end
  endtask

  task automatic test_reset_mid();
    int nwe = 0;
    int nflag = 0;
    for (int i = 0; i < 1024; i++) rom_chr[i] = 12'($urandom_range(4095, 1));
    issue(2'd1, 5'd7, 4'd9);
    capture(500, 1, 0, 5'd0, 4'd0);
    for (int c = 1; c <= 500; c++) if (obs_we[c] === 1'b1) nwe++;
    checks++; if (nwe != 499) begin errors++; $display("[TB] FAIL rstmid_partial: got %0d expected 499", nwe); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_we: got %b expected 0", vram_we); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    rst = 1'b0;
    capture(600, 0, 0, 5'd0, 4'd0);
    for (int c = 1; c <= 600; c++) if (obs_done[c] !== 1'b0 || obs_err[c] !== 1'b0 || obs_we[c] !== 1'b0) nflag++;
    checks++; if (nflag != 0) begin errors++; $display("[TB] FAIL rstmid_no_done: got %0d active cycles expected 0", nflag); end
    issue(2'd1, 5'd7, 4'd9);
    capture(1028, 1, 0, 5'd0, 4'd0);
    nwe = 0;
    for (int c = 1; c <= 1028; c++) if (obs_we[c] === 1'b1) nwe++;
    checks++; if (nwe != 1024) begin errors++; $display("[TB] FAIL rstmid_rerun_count: got %0d expected 1024", nwe); end
    checks++; if (obs_done[1026] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_rerun_done: got %b expected 1", obs_done[1026]); end
  endtask

  task automatic test_key();
    int nwe = 0;
    int exp_n;
    for (int i = 0; i < 1024; i++) rom_chr[i] = (i % 2 == 0) ? 12'h000 : 12'($urandom_range(4095, 1));
    exp_n = KEY_EN ? 512 : 1024;
    issue(2'd1, 5'($urandom_range(19)), 4'($urandom_range(14)));
    capture(1030, 1, 0, 5'd0, 4'd0);
    for (int c = 1; c <= 1030; c++) if (obs_we[c] === 1'b1) nwe++;
    checks++; if (nwe != exp_n) begin errors++; $display("[TB] FAIL key_count: got %0d expected %0d", nwe, exp_n); end
    checks++; if (obs_we[2] !== !KEY_EN) begin errors++; $display("[TB] FAIL key_slot0: got %b expected %b", obs_we[2], !KEY_EN); end
    checks++; if (obs_we[3] !== 1'b1) begin errors++; $display("[TB] FAIL key_slot1: got %b expected 1", obs_we[3]); end
    checks++; if (obs_done[1026] !== 1'b1) begin errors++; $display("[TB] FAIL key_done: got %b expected 1", obs_done[1026]); end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_sel   = 2'd0;
    cmd_tx    = 5'd0;
    cmd_ty    = 4'd0;
    for (int i = 0; i < 1024; i++) begin
      rom_bg[i]   = 12'h000;
      rom_chr[i]  = 12'h000;
      rom_wall[i] = 12'h000;
    end
    test_reset();
    test_copy(0, 0, 0, 1'b1);
    for (int k = 0; k < 2; k++)
      test_copy($urandom_range(2), $urandom_range(19), $urandom_range(14), 1'b0);
    test_corner();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
